// File: rtl/reaction_timer.sv
// Reaction timer: random wait, go cue, then time the button press in ms.
// A false start (press while waiting) and no press at all (timeout) are both reported.
module reaction_timer #(
  parameter int unsigned FREQ         = 100_000_000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter int unsigned MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        press,
  output logic        led_go,
  output logic        busy,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        early,
  output logic        timeout
);

  localparam int unsigned TickDiv = FREQ / 1000;
  localparam int unsigned PrescW  = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TickDiv - 1);
  localparam logic [13:0] MsMax    = 14'(MAX_MS);
  localparam logic [15:0] MinDelay = 16'(MIN_DELAY_MS);

  typedef enum logic [1:0] {StIdle, StWait, StGo, StDone} state_e;

  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [13:0]       ms_q, ms_d;
  logic [15:0]       delay_q, delay_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              led_go_q, led_go_d;
  logic              busy_q, busy_d;
  logic [13:0]       result_q, result_d;
  logic              valid_q, valid_d;
  logic              early_q, early_d;
  logic              timeout_q, timeout_d;
  logic              tick;
  logic              entry;
  logic              timing;

  assign tick   = (presc_q == PrescLast);
  assign timing = (state_q == StWait) || (state_q == StGo);

  // Next-state and result flags; press always has priority over the timed conditions.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    early_d   = early_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press) state_d = StWait;
      end
      StWait: begin
        if (press) begin
          state_d   = StDone;
          early_d   = 1'b1;
          timeout_d = 1'b0;
          result_d  = '0;
          valid_d   = 1'b1;
        end else if ({2'b00, ms_q} == delay_q) begin
          state_d = StGo;
        end
      end
      StGo: begin
        if (press) begin
          state_d   = StDone;
          early_d   = 1'b0;
          timeout_d = 1'b0;
          result_d  = ms_q;
          valid_d   = 1'b1;
        end else if (ms_q == MsMax) begin
          state_d   = StDone;
          early_d   = 1'b0;
          timeout_d = 1'b1;
          result_d  = MsMax;
          valid_d   = 1'b1;
        end
      end
      StDone: begin
        if (press) state_d = StWait;
      end
      default: state_d = StIdle;
    endcase
    entry    = (state_d != state_q);
    led_go_d = (state_d == StGo);
    busy_d   = (state_d == StWait) || (state_d == StGo);
  end

  // Prescaler, ms counter, delay latch and LFSR; both counters restart on every state entry.
  always_comb begin
    presc_d = presc_q + 1'b1;
    if (entry || tick) presc_d = '0;
    ms_d = ms_q;
    if (entry) begin
      ms_d = '0;
    end else if (tick && timing && (ms_q != MsMax)) begin
      ms_d = ms_q + 14'd1;
    end
    delay_d = delay_q;
    if (entry && (state_d == StWait)) delay_d = MinDelay + 16'(lfsr_q[RAND_BITS-1:0]);
    // x^16+x^14+x^13+x^11+1, Fibonacci form shifting right
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      ms_q      <= '0;
      delay_q   <= '0;
      lfsr_q    <= 16'hACE1;
      led_go_q  <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      delay_q   <= delay_d;
      lfsr_q    <= lfsr_d;
      led_go_q  <= led_go_d;
      busy_q    <= busy_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
    end
  end

  assign led_go       = led_go_q;
  assign busy         = busy_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign early        = early_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer at 4 cycles/ms, 2..3 ms random delay, 20 ms timeout.
module tb_reaction_timer;

  localparam int unsigned FREQ         = 4000;
  localparam int unsigned MIN_DELAY_MS = 2;
  localparam int unsigned RAND_BITS    = 1;
  localparam int unsigned MAX_MS       = 20;
  localparam int          Cpm          = 4;   // cycles per ms

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        press = 1'b0;
  logic        led_go, busy, result_valid, early, timeout;
  logic [13:0] result_ms;
  logic [15:0] m_lfsr;

  int n_tests = 0;
  int n_fail  = 0;

  reaction_timer #(
    .FREQ(FREQ), .MIN_DELAY_MS(MIN_DELAY_MS), .RAND_BITS(RAND_BITS), .MAX_MS(MAX_MS)
  ) dut (
    .clk(clk), .rstn(rstn), .press(press), .led_go(led_go), .busy(busy),
    .result_ms(result_ms), .result_valid(result_valid), .early(early), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps at exponents 16,14,13,11 are bits 0,2,3,5 of a right-shifting register.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  // Completed ms after d cycles in GO (press sampled on cycle d+1).
  function automatic int ms_after(input int d);
    int v;
    v = d / Cpm;
    return (v > int'(MAX_MS)) ? int'(MAX_MS) : v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Press from IDLE/DONE; returns the delay target the DUT must latch.
  task automatic begin_round(output int t);
    press = 1'b1;
    t = int'(MIN_DELAY_MS) + (int'(m_lfsr) % (1 << RAND_BITS));
    step();
    press = 1'b0;
  endtask

  // Cycles from WAIT entry until led_go is seen (bounded).
  task automatic wait_go(output int k);
    k = 0;
    while (led_go !== 1'b1 && k < 200) begin
      step();
      k++;
    end
  endtask

  task automatic press_after(input int d);
    repeat (d) step();
    press = 1'b1;
    step();
    press = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    n_tests++;
    if ({led_go, busy, result_valid, early, timeout} !== 5'b0 || result_ms !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got go=%b busy=%b rv=%b early=%b to=%b ms=%0d, required all 0",
               led_go, busy, result_valid, early, timeout, result_ms);
    end
    rstn = 1'b1;
    repeat (6) step();
    n_tests++;
    if ({led_go, busy, result_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got go=%b busy=%b rv=%b, required 0 0 0", led_go, busy, result_valid);
    end
  endtask

  task automatic test_react();
    int t, k, d;
    int dl[6] = '{12, 0, 3, 4, 79, 37};
    for (int i = 0; i < 6; i++) begin
      d = dl[i];
      begin_round(t);
      n_tests++;
      if (busy !== 1'b1 || led_go !== 1'b0 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL react_start: got busy=%b go=%b rv=%b, required 1 0 0", busy, led_go, result_valid);
      end
      wait_go(k);
      n_tests++;
      if (k != Cpm * t + 1) begin
        n_fail++;
        $display("FAIL go_delay: got %0d cycles, required %0d", k, Cpm * t + 1);
      end
      press_after(d);
      n_tests++;
      if ({result_valid, early, timeout, led_go, busy} !== 5'b10000 || int'(result_ms) != ms_after(d)) begin
        n_fail++;
        $display("FAIL react_result d=%0d: got rv=%b e=%b to=%b go=%b busy=%b ms=%0d, required 1 0 0 0 0 ms=%0d",
                 d, result_valid, early, timeout, led_go, busy, result_ms, ms_after(d));
      end
      step();
      n_tests++;
      if (result_valid !== 1'b0 || int'(result_ms) != ms_after(d) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL result_hold: got rv=%b ms=%0d busy=%b, required 0 %0d 0",
                 result_valid, result_ms, busy, ms_after(d));
      end
    end
  endtask

  task automatic test_early();
    int t, m;
    bit seen_go;
    for (int mode = 0; mode < 6; mode++) begin
      begin_round(t);
      case (mode)
        0:       m = 1;
        1:       m = 2;
        2:       m = Cpm * t + 1;   // same cycle as the WAIT->GO condition
        default: m = int'($urandom_range(1, Cpm * t + 1));
      endcase
      seen_go = 1'b0;
      for (int j = 1; j < m; j++) begin
        if (led_go === 1'b1) seen_go = 1'b1;
        step();
      end
      press_after(0);
      n_tests++;
      if ({result_valid, early, timeout, led_go, busy} !== 5'b11000 || result_ms !== 14'd0 || seen_go) begin
        n_fail++;
        $display("FAIL early m=%0d: got rv=%b e=%b to=%b go=%b busy=%b ms=%0d seen_go=%b, required 1 1 0 0 0 ms=0 seen_go=0",
                 m, result_valid, early, timeout, led_go, busy, result_ms, seen_go);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    int t, k;
    begin_round(t);
    wait_go(k);
    k = 0;
    while (result_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    // ms reaches 20 after 80 cycles; DONE is registered one cycle later
    n_tests++;
    if (k != Cpm * int'(MAX_MS) + 1) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d", k, Cpm * int'(MAX_MS) + 1);
    end
    n_tests++;
    if ({early, timeout, led_go, busy} !== 4'b0100 || result_ms !== 14'(MAX_MS)) begin
      n_fail++;
      $display("FAIL timeout_result: got e=%b to=%b go=%b busy=%b ms=%0d, required 0 1 0 0 ms=%0d",
               early, timeout, led_go, busy, result_ms, MAX_MS);
    end
    step();
    begin_round(t);
    wait_go(k);
    press_after(Cpm * int'(MAX_MS));   // press on the timeout cycle wins
    n_tests++;
    if ({result_valid, early, timeout} !== 3'b100 || result_ms !== 14'(MAX_MS)) begin
      n_fail++;
      $display("FAIL timeout_press: got rv=%b e=%b to=%b ms=%0d, required 1 0 0 ms=%0d",
               result_valid, early, timeout, result_ms, MAX_MS);
    end
  endtask

  task automatic test_back_to_back();
    int t, k;
    // result_valid is high right now from the previous test
    n_tests++;
    if (result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_setup: got rv=%b, required 1", result_valid);
    end
    begin_round(t);
    n_tests++;
    if (busy !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b rv=%b, required 1 0", busy, result_valid);
    end
    wait_go(k);
    n_tests++;
    if (k != Cpm * t + 1) begin
      n_fail++;
      $display("FAIL b2b_go_delay: got %0d, required %0d", k, Cpm * t + 1);
    end
    press_after(5);
    n_tests++;
    if ({result_valid, early, timeout} !== 3'b100 || int'(result_ms) != ms_after(5)) begin
      n_fail++;
      $display("FAIL b2b_result: got rv=%b e=%b to=%b ms=%0d, required 1 0 0 ms=%0d",
               result_valid, early, timeout, result_ms, ms_after(5));
    end
    step();
  endtask

  task automatic test_reset_mid();
    int t, k;
    begin_round(t);
    wait_go(k);
    repeat (5) step();
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({led_go, busy, result_valid, early, timeout} !== 5'b0 || result_ms !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_async: got go=%b busy=%b rv=%b e=%b to=%b ms=%0d, required all 0",
               led_go, busy, result_valid, early, timeout, result_ms);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) step();
    n_tests++;
    if (busy !== 1'b0 || led_go !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b go=%b, required 0 0", busy, led_go);
    end
    begin_round(t);
    wait_go(k);
    n_tests++;
    if (k != Cpm * t + 1) begin
      n_fail++;
      $display("FAIL reset_newround: got %0d, required %0d", k, Cpm * t + 1);
    end
    press_after(2);
    step();
  endtask

  task automatic test_random_rounds();
    int t, k, d, m, kind, exp_ms;
    bit seen_go;
    for (int r = 0; r < 1000; r++) begin
      begin_round(t);
      n_tests++;
      if (busy !== 1'b1 || dut.lfsr_q === 16'h0 || dut.lfsr_q !== m_lfsr) begin
        n_fail++;
        $display("FAIL rnd_start r=%0d: got busy=%b lfsr=%h, required 1 lfsr=%h",
                 r, busy, dut.lfsr_q, m_lfsr);
      end
      kind = int'($urandom_range(0, 7));
      if (kind < 2) begin
        m = int'($urandom_range(1, Cpm * t + 1));
        seen_go = 1'b0;
        for (int j = 1; j < m; j++) begin
          if (led_go === 1'b1) seen_go = 1'b1;
          step();
        end
        press_after(0);
        n_tests++;
        if ({result_valid, early, timeout} !== 3'b110 || result_ms !== 14'd0 || seen_go) begin
          n_fail++;
          $display("FAIL rnd_early r=%0d m=%0d: got rv=%b e=%b to=%b ms=%0d go_seen=%b, required 1 1 0 0 0",
                   r, m, result_valid, early, timeout, result_ms, seen_go);
        end
      end else begin
        wait_go(k);
        n_tests++;
        if (k != Cpm * t + 1) begin
          n_fail++;
          $display("FAIL rnd_go_delay r=%0d: got %0d, required %0d", r, k, Cpm * t + 1);
        end
        if (kind == 7) begin
          k = 0;
          while (result_valid !== 1'b1 && k < 200) begin
            step();
            k++;
          end
          n_tests++;
          if (k != Cpm * int'(MAX_MS) + 1 || {early, timeout} !== 2'b01 || result_ms !== 14'(MAX_MS)) begin
            n_fail++;
            $display("FAIL rnd_timeout r=%0d: got k=%0d e=%b to=%b ms=%0d, required k=%0d 0 1 ms=%0d",
                     r, k, early, timeout, result_ms, Cpm * int'(MAX_MS) + 1, MAX_MS);
          end
        end else begin
          d = int'($urandom_range(0, Cpm * int'(MAX_MS)));
          exp_ms = ms_after(d);
          press_after(d);
          n_tests++;
          if ({result_valid, early, timeout, led_go} !== 4'b1000 || int'(result_ms) != exp_ms) begin
            n_fail++;
            $display("FAIL rnd_react r=%0d d=%0d: got rv=%b e=%b to=%b go=%b ms=%0d, required 1 0 0 0 ms=%0d",
                     r, d, result_valid, early, timeout, led_go, result_ms, exp_ms);
          end
        end
      end
      // Half the time press again while result_valid is still high.
      if ($urandom_range(0, 1) == 0) begin
        step();
        n_tests++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_pulse r=%0d: got rv=%b busy=%b, required 0 0", r, result_valid, busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_react();
    test_early();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random_rounds();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
